// File: rtl/seg7_scan_if.sv
// Multiplexed 7-segment display bus: active-low segments and anodes.
// The display driver is the master; a capture block listens as slave.
interface seg7_scan_if #(
  parameter int DIGITS = 4
);
  logic [7:0]        seg;
  logic [DIGITS-1:0] an;

  modport master (
    output seg,
    output an
  );

  modport slave (
    input seg,
    input an
  );
endinterface

// File: rtl/seg7_scan_capture.sv
// Recovers BCD digit, decimal point and status per position from a
// multiplexed active-low 7-segment bus, with a dwell stability filter.
module seg7_scan_capture #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  seg7_scan_if.slave          bus,
  output logic [4*DIGITS-1:0] digits,
  output logic [DIGITS-1:0]   dp,
  output logic [DIGITS-1:0]   blank,
  output logic [DIGITS-1:0]   err,
  output logic                frame_valid
);

  localparam int SW = DIGITS + 8;
  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] C_HIT = CNT_W'(STABLE_CYCLES - 1);

  logic [7:0]        seg_s1;
  logic [7:0]        seg_s2;
  logic [DIGITS-1:0] an_s1;
  logic [DIGITS-1:0] an_s2;

  logic [SW-1:0]     samp;
  logic [SW-1:0]     prev;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic [DIGITS-1:0] seen;
  logic [DIGITS-1:0] commit_mask;

  logic              valid;
  logic              same;
  logic              commit;

  logic [3:0]        dec_val;
  logic              dec_blank;
  logic              dec_err;

  // Two-flop synchronisers; idle bus is all ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1 <= '1;
      seg_s2 <= '1;
      an_s1  <= '1;
      an_s2  <= '1;
    end else begin
      seg_s1 <= bus.seg;
      seg_s2 <= seg_s1;
      an_s1  <= bus.an;
      an_s2  <= an_s1;
    end
  end

  assign samp  = {an_s2, seg_s2};
  assign valid = ($countones(~an_s2) == 1);
  assign same  = (samp == prev);

  // Only a dwell reaching the threshold commits; saturation blocks repeats
  assign commit = valid && same && (cnt == C_HIT);

  assign commit_mask = commit ? ~an_s2 : '0;

  always_comb begin
    cnt_next = '0;
    if (valid) begin
      if (same) begin
        cnt_next = (cnt == C_MAX) ? cnt : cnt + 1'b1;
      end else begin
        cnt_next = CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= '1;
      cnt  <= '0;
    end else begin
      prev <= samp;
      cnt  <= cnt_next;
    end
  end

  always_comb begin
    dec_val   = 4'hF;
    dec_blank = 1'b0;
    dec_err   = 1'b0;
    unique case (seg_s2[6:0])
      7'h40:   dec_val = 4'd0;
      7'h79:   dec_val = 4'd1;
      7'h24:   dec_val = 4'd2;
      7'h30:   dec_val = 4'd3;
      7'h19:   dec_val = 4'd4;
      7'h12:   dec_val = 4'd5;
      7'h02:   dec_val = 4'd6;
      7'h58:   dec_val = 4'd7;
      7'h00:   dec_val = 4'd8;
      7'h10:   dec_val = 4'd9;
      7'h7F:   dec_blank = 1'b1;
      default: dec_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits <= '1;
      dp     <= '0;
      blank  <= '1;
      err    <= '0;
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        if (commit_mask[i]) begin
          digits[4*i +: 4] <= dec_val;
          dp[i]            <= ~seg_s2[7];
          blank[i]         <= dec_blank;
          err[i]           <= dec_err;
        end
      end
    end
  end

  // A commit landing on the clearing edge counts toward the next frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen        <= '0;
      frame_valid <= 1'b0;
    end else if (&seen) begin
      seen        <= commit_mask;
      frame_valid <= 1'b1;
    end else begin
      seen        <= seen | commit_mask;
      frame_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture: reset, scan recovery, dwell
// threshold, blank/error codes, invalid anodes and ghost rejection.
module tb_seg7_scan_capture;

  logic        clk;
  logic        rst_n;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic [3:0]  err;
  logic        frame_valid;

  int checks;
  int errors;
  int fv_cnt;

  seg7_scan_if #(.DIGITS(4)) bus ();

  seg7_scan_capture #(
    .DIGITS(4),
    .STABLE_CYCLES(16),
    .CNT_W(5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .digits(digits),
    .dp(dp),
    .blank(blank),
    .err(err),
    .frame_valid(frame_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid === 1'b1) fv_cnt++;
  end

  // Pins change on a negedge and are seen by exactly n rising edges
  task automatic hold(input logic [3:0] a, input logic [7:0] s,
                      input int n);
    @(negedge clk);
    bus.an  = a;
    bus.seg = s;
    repeat (n) @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.an  = 4'hF;
    bus.seg = 8'hFF;
    rst_n   = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
  endtask

  task automatic test_reset();
    checks++;
    if (digits !== 16'hFFFF) begin
      errors++;
      $display("FAIL por_digits got %h exp FFFF", digits);
    end
    hold(4'hE, 8'h00, 20);
    hold(4'hF, 8'hFF, 2);
    @(negedge clk);
    checks++;
    if (digits[3:0] !== 4'h8 || dp[0] !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst got d=%h dp=%b exp d=8 dp=1",
               digits[3:0], dp[0]);
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (digits !== 16'hFFFF) begin
      errors++;
      $display("FAIL rst_digits got %h exp FFFF", digits);
    end
    checks++;
    if (blank !== 4'hF) begin
      errors++;
      $display("FAIL rst_blank got %h exp F", blank);
    end
    checks++;
    if (err !== 4'h0) begin
      errors++;
      $display("FAIL rst_err got %h exp 0", err);
    end
    checks++;
    if (dp !== 4'h0) begin
      errors++;
      $display("FAIL rst_dp got %h exp 0", dp);
    end
    checks++;
    if (frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_fv got %b exp 0", frame_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_scan();
    int f0;
    int f1;
    do_reset();
    f0 = fv_cnt;
    hold(4'hE, 8'hA4, 32);
    hold(4'hD, 8'hB0, 32);
    hold(4'hB, 8'h99, 32);
    hold(4'h7, 8'hF9, 32);
    f1 = fv_cnt;
    checks++;
    if (f1 - f0 !== 1) begin
      errors++;
      $display("FAIL scan1_fv got %0d exp 1", f1 - f0);
    end
    hold(4'hE, 8'hA4, 32);
    hold(4'hD, 8'hB0, 32);
    hold(4'hB, 8'h99, 32);
    hold(4'h7, 8'hF9, 32);
    hold(4'hF, 8'hFF, 6);
    @(negedge clk);
    checks++;
    if (fv_cnt - f0 !== 2) begin
      errors++;
      $display("FAIL scan2_fv got %0d exp 2", fv_cnt - f0);
    end
    checks++;
    if (digits !== 16'h1432) begin
      errors++;
      $display("FAIL scan_digits got %h exp 1432", digits);
    end
    checks++;
    if (blank !== 4'h0 || err !== 4'h0) begin
      errors++;
      $display("FAIL scan_status got b=%h e=%h exp 0 0", blank, err);
    end
    checks++;
    if (dp !== 4'h0) begin
      errors++;
      $display("FAIL scan_dp got %h exp 0", dp);
    end
  endtask

  task automatic test_threshold();
    do_reset();
    hold(4'hE, 8'h80, 17);
    @(negedge clk);
    bus.an  = 4'hF;
    bus.seg = 8'hFF;
    checks++;
    if (digits[3:0] !== 4'hF) begin
      errors++;
      $display("FAIL thr_early got %h exp F", digits[3:0]);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (digits[3:0] !== 4'h8 || dp[0] !== 1'b0 || blank[0] !== 1'b0) begin
      errors++;
      $display("FAIL thr_commit got d=%h dp=%b b=%b exp d=8 dp=0 b=0",
               digits[3:0], dp[0], blank[0]);
    end
    hold(4'hF, 8'hFF, 3);
    hold(4'hE, 8'h00, 17);
    hold(4'hF, 8'hFF, 4);
    @(negedge clk);
    checks++;
    if (digits[3:0] !== 4'h8 || dp[0] !== 1'b1) begin
      errors++;
      $display("FAIL thr_dp got d=%h dp=%b exp d=8 dp=1",
               digits[3:0], dp[0]);
    end
    hold(4'hE, 8'hF9, 10);
    hold(4'hF, 8'hFF, 8);
    @(negedge clk);
    checks++;
    if (digits[3:0] !== 4'h8 || dp[0] !== 1'b1) begin
      errors++;
      $display("FAIL thr_short got d=%h dp=%b exp d=8 dp=1",
               digits[3:0], dp[0]);
    end
  endtask

  task automatic test_codes();
    do_reset();
    hold(4'hD, 8'hB0, 20);
    hold(4'hF, 8'hFF, 3);
    @(negedge clk);
    checks++;
    if (digits[7:4] !== 4'h3 || blank[1] !== 1'b0) begin
      errors++;
      $display("FAIL code_3 got d=%h b=%b exp d=3 b=0",
               digits[7:4], blank[1]);
    end
    hold(4'hD, 8'hFF, 20);
    hold(4'hF, 8'hFF, 3);
    @(negedge clk);
    checks++;
    if (digits[7:4] !== 4'hF || blank[1] !== 1'b1 || err[1] !== 1'b0) begin
      errors++;
      $display("FAIL code_blank got d=%h b=%b e=%b exp d=F b=1 e=0",
               digits[7:4], blank[1], err[1]);
    end
    hold(4'hD, 8'h7E, 20);
    hold(4'hF, 8'hFF, 3);
    @(negedge clk);
    checks++;
    if (digits[7:4] !== 4'hF || blank[1] !== 1'b0 || err[1] !== 1'b1) begin
      errors++;
      $display("FAIL code_err got d=%h b=%b e=%b exp d=F b=0 e=1",
               digits[7:4], blank[1], err[1]);
    end
    checks++;
    if (dp[1] !== 1'b1 || digits[3:0] !== 4'hF) begin
      errors++;
      $display("FAIL code_other got dp=%b d0=%h exp dp=1 d0=F",
               dp[1], digits[3:0]);
    end
  endtask

  task automatic test_invalid_an();
    int f0;
    do_reset();
    f0 = fv_cnt;
    hold(4'hC, 8'h40, 40);
    hold(4'hF, 8'h40, 40);
    hold(4'hF, 8'hFF, 4);
    @(negedge clk);
    checks++;
    if (digits !== 16'hFFFF || blank !== 4'hF) begin
      errors++;
      $display("FAIL inv_commit got d=%h b=%h exp FFFF F", digits, blank);
    end
    checks++;
    if (fv_cnt - f0 !== 0) begin
      errors++;
      $display("FAIL inv_fv got %0d exp 0", fv_cnt - f0);
    end
  endtask

  task automatic test_ghost();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      hold(4'hE, (i % 2 == 0) ? 8'h40 : 8'h41, 8);
    end
    checks++;
    if (digits[3:0] !== 4'hF || err[0] !== 1'b0) begin
      errors++;
      $display("FAIL ghost_commit got d=%h e=%b exp F 0",
               digits[3:0], err[0]);
    end
    hold(4'hE, 8'h40, 17);
    @(negedge clk);
    checks++;
    if (digits[3:0] !== 4'hF) begin
      errors++;
      $display("FAIL ghost_early got %h exp F", digits[3:0]);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (digits[3:0] !== 4'h0 || blank[0] !== 1'b0) begin
      errors++;
      $display("FAIL ghost_commit18 got d=%h b=%b exp 0 0",
               digits[3:0], blank[0]);
    end
    hold(4'hF, 8'hFF, 2);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    fv_cnt  = 0;
    rst_n   = 1'b0;
    bus.an  = 4'hF;
    bus.seg = 8'hFF;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_scan();
    test_threshold();
    test_codes();
    test_invalid_an();
    test_ghost();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
